// File: rtl/eq_coef_sweep_ctrl.sv
// eq_coef_sweep_ctrl
//   Training sequencer for the RX channel equalizer. On start it loads each of
//   NUM_SETS coefficient sets in turn. After each load it waits SETTLE_CYC
//   cycles, then counts decision errors (rx vs expected bit) over WINDOW valid
//   bits. When the sweep ends it reloads the set with the fewest errors and
//   reports lock.
// Ports
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_start, i_abort        begin sweep (IDLE/LOCKED only) / abandon to IDLE
//   i_bit_valid             qualifies i_rx_bit / i_exp_bit
//   i_rx_bit, i_exp_bit     sliced decision and expected training bit
//   o_coef_sel, o_coef_load set index to equalizer and its one-cycle adopt pulse
//   o_busy, o_lock          sweep in progress / best set applied
//   o_best_sel, o_best_err  winning set index and its error count
module eq_coef_sweep_ctrl #(
    parameter int unsigned NUM_SETS   = 8,
    parameter int unsigned SEL_W      = 3,
    parameter int unsigned SETTLE_CYC = 16,
    parameter int unsigned WINDOW     = 256,
    parameter int unsigned ERR_W      = 10
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic             i_bit_valid,
    input  logic             i_rx_bit,
    input  logic             i_exp_bit,
    output logic [SEL_W-1:0] o_coef_sel,
    output logic             o_coef_load,
    output logic             o_busy,
    output logic             o_lock,
    output logic [SEL_W-1:0] o_best_sel,
    output logic [ERR_W-1:0] o_best_err
);

    localparam int unsigned SC_W = $clog2(SETTLE_CYC + 1);
    localparam int unsigned BC_W = $clog2(WINDOW + 1);

    localparam logic [SEL_W-1:0] LAST_IDX    = SEL_W'(NUM_SETS - 1);
    localparam logic [SC_W-1:0]  SETTLE_LAST = SC_W'(SETTLE_CYC - 1);
    localparam logic [BC_W-1:0]  WIN_LAST    = BC_W'(WINDOW - 1);
    localparam logic [ERR_W-1:0] ERR_MAX     = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_MEASURE,
        S_COMPARE,
        S_FINAL,
        S_LOCKED
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [SEL_W-1:0] r_idx;
    logic [SEL_W-1:0] r_coef_sel;
    logic [SEL_W-1:0] r_best_sel;
    logic [ERR_W-1:0] r_best_err;
    logic [ERR_W-1:0] r_err_cnt;
    logic [SC_W-1:0]  r_settle_cnt;
    logic [BC_W-1:0]  r_bit_cnt;
    logic             w_coef_load;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_LOCKED: if (i_start) w_next = S_LOAD;
            S_LOAD:           w_next = S_SETTLE;
            S_SETTLE:         if (r_settle_cnt == SETTLE_LAST) w_next = S_MEASURE;
            S_MEASURE:        if (i_bit_valid && (r_bit_cnt == WIN_LAST)) w_next = S_COMPARE;
            S_COMPARE:        w_next = (r_idx == LAST_IDX) ? S_FINAL : S_LOAD;
            S_FINAL:          w_next = S_LOCKED;
            default:          w_next = S_IDLE;
        endcase
        // abort outranks every transition, including a start in IDLE/LOCKED
        if (i_abort) w_next = S_IDLE;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_idx        <= '0;
            r_coef_sel   <= '0;
            r_best_sel   <= '0;
            r_best_err   <= '1;
            r_err_cnt    <= '0;
            r_settle_cnt <= '0;
            r_bit_cnt    <= '0;
        end else begin
            // remember whatever the equalizer last adopted so it holds after abort
            if (w_coef_load) r_coef_sel <= o_coef_sel;
            case (r_state)
                S_IDLE, S_LOCKED: begin
                    if (i_start && !i_abort) begin
                        r_idx      <= '0;
                        r_best_sel <= '0;
                        r_best_err <= '1;
                    end
                end
                S_LOAD: begin
                    r_settle_cnt <= '0;
                    r_bit_cnt    <= '0;
                    r_err_cnt    <= '0;
                end
                S_SETTLE: r_settle_cnt <= r_settle_cnt + SC_W'(1);
                S_MEASURE: begin
                    if (i_bit_valid) begin
                        r_bit_cnt <= r_bit_cnt + BC_W'(1);
                        if ((i_rx_bit != i_exp_bit) && (r_err_cnt != ERR_MAX))
                            r_err_cnt <= r_err_cnt + ERR_W'(1);
                    end
                end
                S_COMPARE: begin
                    if (!i_abort) begin
                        // strict compare: ties keep the earlier (lower) index
                        if (r_err_cnt < r_best_err) begin
                            r_best_sel <= r_idx;
                            r_best_err <= r_err_cnt;
                        end
                        if (r_idx != LAST_IDX) r_idx <= r_idx + SEL_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_coef_load = (r_state == S_LOAD) || (r_state == S_FINAL);
        o_coef_sel  = r_coef_sel;
        if (r_state == S_LOAD)  o_coef_sel = r_idx;
        if (r_state == S_FINAL) o_coef_sel = r_best_sel;
    end

    assign o_coef_load = w_coef_load;
    assign o_busy      = (r_state != S_IDLE) && (r_state != S_LOCKED);
    assign o_lock      = (r_state == S_LOCKED);
    assign o_best_sel  = r_best_sel;
    assign o_best_err  = r_best_err;

endmodule

// File: doc/eq_coef_sweep_ctrl.md
Name: eq_coef_sweep_ctrl

Overview:
Training sequencer for the RX channel equalizer. On start it steps through NUM_SETS stored equalizer coefficient sets. For each set it waits a settling time, then counts decision errors of the sliced equalizer output against the expected training pattern over a fixed window. When the sweep ends it loads the set with the fewest errors and reports lock. It sits between the RX training/PRBS checker and the equalizer coefficient-select input.

Parameters:
NUM_SETS, 8, number of coefficient sets swept (2..256)
SEL_W, 3, width of set index; must satisfy 2**SEL_W >= NUM_SETS
SETTLE_CYC, 16, clk cycles waited after each load before measuring (>=1)
WINDOW, 256, number of valid bits compared per set (>=1)
ERR_W, 10, error counter width; counter saturates at 2**ERR_W-1

Ports:
clk  in  1  clock, all state on posedge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin sweep; sampled only in IDLE or LOCKED
abort  in  1  abandon sweep, return to IDLE
bit_valid  in  1  qualifies rx_bit/exp_bit this cycle
rx_bit  in  1  equalizer sliced decision
exp_bit  in  1  expected training bit
coef_sel  out  SEL_W  coefficient set index driven to equalizer
coef_load  out  1  one-cycle pulse: equalizer adopts coef_sel
busy  out  1  high in any state other than IDLE/LOCKED
lock  out  1  high in LOCKED
best_sel  out  SEL_W  winning set index
best_err  out  ERR_W  error count of winning set

Behaviour:
- Reset (async assert, sync release): state IDLE; coef_sel=0, coef_load=0, busy=0, lock=0, best_sel=0, best_err=all ones, internal counters 0.
- States: IDLE, LOAD, SETTLE, MEASURE, COMPARE, FINAL, LOCKED.
- IDLE/LOCKED with start=1: next cycle LOAD, idx=0, best_err reset to all ones, lock drops that same edge.
- LOAD (1 cycle): coef_sel=idx, coef_load=1, settle counter cleared; next SETTLE.
- SETTLE: counts SETTLE_CYC clk cycles, ignores bit_valid; next MEASURE.
- MEASURE: each cycle with bit_valid=1, bit counter +1; error counter +1 if rx_bit!=exp_bit, saturating at 2**ERR_W-1. After WINDOW valid bits (the counted bit is included), go to COMPARE. bit_valid=0 stalls without timeout.
- COMPARE (1 cycle): if err < best_err then best_sel=idx, best_err=err. Ties keep the lower index. The first set always wins because best_err starts at all ones, unless saturated; on a saturated tie set 0 is kept. If idx==NUM_SETS-1, go to FINAL; else idx+1 and go to LOAD.
- FINAL (1 cycle): coef_sel=best_sel, coef_load=1; next LOCKED.
- LOCKED: lock=1, coef_sel holds best_sel, coef_load=0, outputs stable until start or abort.
- coef_load is high only in LOAD and FINAL; there are exactly NUM_SETS+1 pulses per full sweep.
- abort has priority over all transitions, including a simultaneous start. Any state goes to IDLE next cycle. coef_sel holds its last value, no coef_load, lock=0, best_* hold. abort in IDLE has no effect.
- start while busy is ignored.
- Reset mid-sweep: immediate return to reset values; no load pulse on release.
- Sweep latency with continuous bit_valid: 1 + NUM_SETS*(1+SETTLE_CYC+WINDOW+1) + 1 cycles from start sample to lock.

Test Plan:
1. NUM_SETS=4, SETTLE_CYC=4, WINDOW=16, bit_valid=1 always. Error injection gives sets 0..3 error counts of 5,2,7,2 -> best_sel=1 (tie with 3 resolves low), best_err=2, coef_load pulses 5 times, lock asserts exactly 1+4*22+1=90 cycles after start.
2. Zero errors on all sets -> best_sel=0, best_err=0, final coef_sel=0, lock=1.
3. Same as 1 but bit_valid high every 3rd cycle -> identical result; MEASURE length 48 cycles per set.
4. abort asserted during MEASURE of set 2 together with start=1 -> IDLE next cycle, busy=0, lock=0, no further coef_load; a later start performs a full sweep again from idx=0.
5. ERR_W=3, all bits wrong for every set -> error count saturates at 7, best_sel=0, best_err=7, no wrap to 0.
6. rst_n pulsed low mid-SETTLE (asynchronous, not clock aligned) -> outputs take reset values immediately; start pulsed in LOCKED re-sweeps with lock low from the next cycle.
